// File: rtl/zymason_loader.sv
// Host-side loader for the 16-digit seven-segment store/display block.
// Streams digits in over valid/ready and replays them as the display's pin-level write protocol.
module zymason_loader #(
  parameter int unsigned NUM_DIGITS = 16,
  parameter int unsigned IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             dig_valid,
  output logic             dig_ready,
  input  logic [6:0]       dig_data,
  input  logic             hex_mode,
  input  logic [4:0]       spd_cfg,
  output logic             rw,
  output logic             sel,
  output logic [3:0]       pin_out,
  output logic             disp_rst,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] digit_idx
);

  typedef enum logic [2:0] {Idle, Clr, Fetch, Lo, Hi, Adv, Exit} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_DIGITS - 1);

  state_e     state;
  logic [3:0] lo;
  logic [3:0] last_lo;
  logic [2:0] hi;
  logic [6:0] seg;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] r;
    r = 7'h00;
    case (v)
      4'h0: r = 7'h3F;
      4'h1: r = 7'h06;
      4'h2: r = 7'h5B;
      4'h3: r = 7'h4F;
      4'h4: r = 7'h66;
      4'h5: r = 7'h6D;
      4'h6: r = 7'h7D;
      4'h7: r = 7'h07;
      4'h8: r = 7'h7F;
      4'h9: r = 7'h6F;
      4'hA: r = 7'h77;
      4'hB: r = 7'h7C;
      4'hC: r = 7'h39;
      4'hD: r = 7'h5E;
      4'hE: r = 7'h79;
      4'hF: r = 7'h71;
      default: r = 7'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    seg = hex_mode ? hex7(dig_data[3:0]) : dig_data;
  end

  // Outputs are loaded with the values belonging to the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= Idle;
      rw        <= 1'b0;
      sel       <= 1'b0;
      pin_out   <= 4'h0;
      disp_rst  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dig_ready <= 1'b0;
      digit_idx <= '0;
      lo        <= 4'h0;
      hi        <= 3'h0;
      last_lo   <= 4'h0;
    end else begin
      done <= 1'b0;
      unique case (state)
        Idle: begin
          rw <= 1'b0;
          if (start) begin
            state     <= Clr;
            busy      <= 1'b1;
            disp_rst  <= 1'b1;
            sel       <= 1'b0;
            pin_out   <= 4'h0;
            digit_idx <= '0;
          end else begin
            sel     <= spd_cfg[0];
            pin_out <= spd_cfg[4:1];
          end
        end
        Clr: begin
          state     <= Fetch;
          disp_rst  <= 1'b0;
          rw        <= 1'b1;
          sel       <= 1'b0;
          pin_out   <= last_lo;
          dig_ready <= 1'b1;
        end
        Fetch: begin
          if (dig_valid && dig_ready) begin
            state     <= Lo;
            dig_ready <= 1'b0;
            lo        <= seg[3:0];
            hi        <= seg[6:4];
            pin_out   <= seg[3:0];
          end
        end
        Lo: begin
          state   <= Hi;
          sel     <= 1'b1;
          pin_out <= {1'b0, hi};
        end
        Hi: begin
          // The display stores lo again on the edge that advances its pointer.
          state   <= Adv;
          sel     <= 1'b0;
          pin_out <= lo;
        end
        Adv: begin
          last_lo <= lo;
          if (digit_idx == LastIdx) begin
            state   <= Exit;
            rw      <= 1'b0;
            sel     <= 1'b1;
            pin_out <= 4'h0;
          end else begin
            state     <= Fetch;
            digit_idx <= digit_idx + 1'b1;
            pin_out   <= lo;
            dig_ready <= 1'b1;
          end
        end
        Exit: begin
          state   <= Idle;
          busy    <= 1'b0;
          done    <= 1'b1;
          rw      <= 1'b0;
          sel     <= spd_cfg[0];
          pin_out <= spd_cfg[4:1];
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: doc/zymason_loader.md
Name: zymason_loader

Overview:
- Host-side writer for the tiny 16-digit seven-segment store/display block.
- Accepts a stream of digit patterns on a valid/ready interface, either raw 7-bit segment patterns or 4-bit hex values that it encodes internally.
- Generates the display's pin-level write protocol on rw/sel/pin_out, then returns the display to scan mode with a configured scroll speed.
- Sits between a host/test controller and the display's io_in[7:1]; both blocks share clock.

Parameters:
- NUM_DIGITS, 16, digits written per frame; must match the display depth.
- IDX_W, 4, width of digit_idx; equals clog2(NUM_DIGITS).

Ports:
- clock  in  1  System clock, shared with the display.
- reset  in  1  Asynchronous, active-high.
- start  in  1  Begin a frame load. Sampled only in IDLE.
- dig_valid  in  1  Digit data valid.
- dig_ready  out  1  Loader accepts a digit this cycle.
- dig_data  in  7  Raw segments, bit0 = seg a … bit6 = seg g. In hex mode only [3:0] is used.
- hex_mode  in  1  1 = encode dig_data[3:0] as hex. Captured with each digit.
- spd_cfg  in  5  Scroll speed, driven as {pin_out, sel} while idle.
- rw  out  1  Display RW, drives io_in[2].
- sel  out  1  Display sel, drives io_in[3].
- pin_out  out  4  Display pin_in, drives io_in[7:4].
- disp_rst  out  1  Display reset pulse, drives io_in[1].
- busy  out  1  High in any state other than IDLE.
- done  out  1  One-cycle pulse when a frame completes.
- digit_idx  out  IDX_W  Index of the digit currently being written.

Behaviour:
- All outputs are registered. "In state S" means the values driven during every cycle the FSM is in S.
- Reset values: rw=0, sel=0, pin_out=0, disp_rst=0, busy=0, done=0, dig_ready=0, digit_idx=0. Internal lo/hi/last_lo registers reset to 0. State = IDLE.
- IDLE:
  - rw=0, sel=spd_cfg[0], pin_out=spd_cfg[4:1], dig_ready=0.
  - start=1 → CLR on the next cycle.
- CLR:
  - Exactly one cycle. disp_rst=1, rw=0, sel=0, pin_out=0, digit_idx=0.
  - Next state FETCH.
- FETCH:
  - rw=1, sel=0, pin_out=last_lo, dig_ready=1.
  - Handshake when dig_valid & dig_ready. On handshake, capture seg:
    - hex_mode=1: seg = hex7(dig_data[3:0]).
    - hex_mode=0: seg = dig_data.
  - Set lo=seg[3:0], hi=seg[2:0] of the high part (seg[6:4]).
  - Next state LO. Otherwise stay in FETCH indefinitely.
- LO: one cycle. rw=1, sel=0, pin_out=lo. Next state HI.
- HI: one cycle. rw=1, sel=1, pin_out={1'b0, hi}. Next state ADV.
- ADV:
  - One cycle. rw=1, sel=0, pin_out=lo. Re-writing lo is mandatory: the display writes the low nibble on the same edge it advances position.
  - last_lo <= lo.
  - If digit_idx == NUM_DIGITS-1 → EXIT; else digit_idx+1 and → FETCH.
- EXIT:
  - One cycle. rw=0, sel=1, pin_out=0. This moves the display WRT0 → WRT1 with no write.
  - Next state IDLE, with done=1 for the first IDLE cycle. The IDLE rw=0 moves the display WRT1 → SCAN.
- Per-digit cost: FETCH (≥1 cycle) + LO + HI + ADV, so 4 cycles minimum. Full frame minimum = 1 + 16·4 + 1 = 66 cycles from the first CLR cycle.
- hex7 table, 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- start while busy is ignored. dig_valid outside FETCH is ignored and never consumed.
- The FETCH write of last_lo into the next digit is benign; that digit is overwritten in LO. After the final ADV the display pointer wraps to digit 0. EXIT must not hold rw=1.
- Loader reset mid-frame: outputs return to reset values immediately. The display may be left in a write state or mid-digit. The next start recovers it via CLR. No partial frame is resumed.
- spd_cfg changes in IDLE propagate to pins with 1-cycle latency.

Test Plan:
- Raw load: start, then 16 back-to-back digits 0x00..0x0F with dig_valid held high → 16 handshakes 4 cycles apart. A behavioural display model holds digit i == i. done pulses at cycle 66, and the model is in SCAN.
- Hex mode: digit 0 hex '0', digit 1 hex 'A', remaining hex 'F' → model digits 0x3F, 0x77, then 0x71 ×14. Pin trace for digit 0: LO pin=F, HI pin=3, ADV pin=F.
- Backpressure: drop dig_valid for 10 cycles before digit 5 → loader stays in FETCH with rw=1, sel=0, pin=last_lo. Digits 0–4 are uncorrupted and the final frame is correct. done arrives 10 cycles later than the stall-free case.
- Start while busy: pulse start at digit 7 → no CLR and no restart. digit_idx continues 7→15 and exactly one done pulse.
- Reset mid-frame: assert reset during HI of digit 3 → all outputs are 0 next cycle. A new start then gives disp_rst for one cycle and a correct full 16-digit frame.
- Idle speed: spd_cfg=5'b10111 in IDLE → sel=1, pin_out=4'b1011 one cycle later. The model's scan advances every 12th pulse period.
